// File: rtl/dcache_ctrl_pkg.sv
// Shared definitions for the direct-mapped write-back data cache:
// FSM state encoding, line/word geometry and address-field helpers.
package dcache_ctrl_pkg;

   localparam int ADDR_W         = 16;
   localparam int LINE_ADDR_W    = 14;
   localparam int WORD_W         = 16;
   localparam int OFFSET_W       = 2;
   localparam int WORDS_PER_LINE = 4;
   localparam int LINE_W         = WORDS_PER_LINE * WORD_W;

   typedef enum logic [1:0] {
      IDLE,
      WB,
      FILL
   } state_t;

   // Line address {tag,index}; tag/index split depends on INDEX_W
   function automatic logic [LINE_ADDR_W-1:0] line_addr(
      input logic [ADDR_W-1:0] a
   );
      return a[ADDR_W-1:OFFSET_W];
   endfunction

   function automatic logic [OFFSET_W-1:0] addr_offset(
      input logic [ADDR_W-1:0] a
   );
      return a[OFFSET_W-1:0];
   endfunction

endpackage

// File: rtl/dcache_ctrl_cache_array.sv
// Tag/valid/dirty/data storage for the data cache. Async read, one write
// port (word store or full line install), async active-low valid/dirty clear.
// Ports: rd_index -> rd_tag/rd_valid/rd_dirty/rd_line; wr_index with
// word_we (wr_offset, wr_word), line_we (wr_tag, wr_line), dirty_clr.
module dcache_ctrl_cache_array
   import dcache_ctrl_pkg::*;
#(
   parameter int INDEX_W = 6,
   parameter int TAG_W   = LINE_ADDR_W - INDEX_W
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [INDEX_W-1:0]  rd_index,
   output logic [TAG_W-1:0]    rd_tag,
   output logic                rd_valid,
   output logic                rd_dirty,
   output logic [LINE_W-1:0]   rd_line,
   input  logic [INDEX_W-1:0]  wr_index,
   input  logic                word_we,
   input  logic [OFFSET_W-1:0] wr_offset,
   input  logic [WORD_W-1:0]   wr_word,
   input  logic                line_we,
   input  logic [TAG_W-1:0]    wr_tag,
   input  logic [LINE_W-1:0]   wr_line,
   input  logic                dirty_clr
);

   localparam int LINES = 1 << INDEX_W;

   logic [TAG_W-1:0]  tag_mem  [LINES];
   logic [LINE_W-1:0] data_mem [LINES];
   logic [LINES-1:0]  valid_q;
   logic [LINES-1:0]  dirty_q;

   assign rd_tag   = tag_mem[rd_index];
   assign rd_line  = data_mem[rd_index];
   assign rd_valid = valid_q[rd_index];
   assign rd_dirty = dirty_q[rd_index];

   always_ff @(posedge clk) begin
      if (line_we) begin
         tag_mem[wr_index]  <= wr_tag;
         data_mem[wr_index] <= wr_line;
      end else if (word_we) begin
         data_mem[wr_index][int'(wr_offset)*WORD_W +: WORD_W] <= wr_word;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (line_we) begin
         valid_q[wr_index] <= 1'b1;
         dirty_q[wr_index] <= 1'b0;
      end else if (word_we) begin
         dirty_q[wr_index] <= 1'b1;
      end else if (dirty_clr) begin
         dirty_q[wr_index] <= 1'b0;
      end
   end

endmodule

// File: rtl/dcache_ctrl.sv
// MEM-stage data cache controller: same-cycle hits, stall on miss, dirty
// victim writeback then line fill over a mem_rdy handshake, miss counter.
// Ports: cpu_* (request/stall/load data), mem_* (line interface), miss_cnt.
module dcache_ctrl
   import dcache_ctrl_pkg::*;
#(
   parameter int INDEX_W    = 6,
   parameter int MISS_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [ADDR_W-1:0]      cpu_addr,
   input  logic                   cpu_rd,
   input  logic                   cpu_wr,
   input  logic [WORD_W-1:0]      cpu_wdata,
   output logic [WORD_W-1:0]      cpu_rdata,
   output logic                   cpu_stall,
   output logic [LINE_ADDR_W-1:0] mem_addr,
   output logic                   mem_rd,
   output logic                   mem_wr,
   output logic [LINE_W-1:0]      mem_wdata,
   input  logic [LINE_W-1:0]      mem_rdata,
   input  logic                   mem_rdy,
   output logic [MISS_CNT_W-1:0]  miss_cnt
);

   localparam int TAG_W = LINE_ADDR_W - INDEX_W;

   state_t                 state;
   logic [LINE_ADDR_W-1:0] cpu_line;
   logic [TAG_W-1:0]       cpu_tag;
   logic [TAG_W-1:0]       miss_tag;
   logic [TAG_W-1:0]       arr_tag;
   logic [INDEX_W-1:0]     cpu_index;
   logic [INDEX_W-1:0]     miss_index;
   logic [INDEX_W-1:0]     arr_index;
   logic [OFFSET_W-1:0]    cpu_offset;
   logic [LINE_W-1:0]      arr_line;
   logic                   arr_valid;
   logic                   arr_dirty;
   logic                   hit;
   logic                   miss;
   logic                   stall_q;
   logic                   word_we;
   logic                   line_we;
   logic                   dirty_clr;

   assign cpu_line   = line_addr(cpu_addr);
   assign cpu_tag    = cpu_line[LINE_ADDR_W-1:INDEX_W];
   assign cpu_index  = cpu_line[INDEX_W-1:0];
   assign cpu_offset = addr_offset(cpu_addr);

   // The miss line is latched so a dropped request cannot disturb the fill
   assign arr_index = (state == IDLE) ? cpu_index : miss_index;

   assign hit       = arr_valid & (arr_tag == cpu_tag);
   assign miss      = (state == IDLE) & (cpu_rd | cpu_wr) & ~hit;
   assign word_we   = (state == IDLE) & cpu_wr & hit;
   assign line_we   = (state == FILL) & mem_rdy;
   assign dirty_clr = (state == WB) & mem_rdy;

   // Stall is raised combinationally on the miss cycle, then held by stall_q
   assign cpu_stall = rst_n & (stall_q | miss);

   // rd+wr together behaves as a store, so no load data is returned
   assign cpu_rdata = ((state == IDLE) & cpu_rd & ~cpu_wr & hit)
                    ? arr_line[int'(cpu_offset)*WORD_W +: WORD_W]
                    : '0;

   dcache_ctrl_cache_array #(
      .INDEX_W (INDEX_W),
      .TAG_W   (TAG_W)
   ) u_array (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_index  (arr_index),
      .rd_tag    (arr_tag),
      .rd_valid  (arr_valid),
      .rd_dirty  (arr_dirty),
      .rd_line   (arr_line),
      .wr_index  (arr_index),
      .word_we   (word_we),
      .wr_offset (cpu_offset),
      .wr_word   (cpu_wdata),
      .line_we   (line_we),
      .wr_tag    (miss_tag),
      .wr_line   (mem_rdata),
      .dirty_clr (dirty_clr)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         stall_q    <= 1'b0;
         mem_rd     <= 1'b0;
         mem_wr     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         miss_tag   <= '0;
         miss_index <= '0;
         miss_cnt   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (miss) begin
                  miss_tag   <= cpu_tag;
                  miss_index <= cpu_index;
                  stall_q    <= 1'b1;
                  if (miss_cnt != '1) begin
                     miss_cnt <= miss_cnt + 1'b1;
                  end
                  if (arr_valid & arr_dirty) begin
                     state     <= WB;
                     mem_wr    <= 1'b1;
                     mem_addr  <= {arr_tag, cpu_index};
                     mem_wdata <= arr_line;
                  end else begin
                     state    <= FILL;
                     mem_rd   <= 1'b1;
                     mem_addr <= {cpu_tag, cpu_index};
                  end
               end
            end
            WB: begin
               if (mem_rdy) begin
                  state    <= FILL;
                  mem_wr   <= 1'b0;
                  mem_rd   <= 1'b1;
                  mem_addr <= {miss_tag, miss_index};
               end
            end
            FILL: begin
               if (mem_rdy) begin
                  state   <= IDLE;
                  mem_rd  <= 1'b0;
                  stall_q <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: flat-memory reference model plus a
// cache-occupancy model predict load data and writeback/fill traffic.
module tb_dcache_ctrl;

   localparam int MCW = 4;
   localparam int CNT_MAX = (1 << MCW) - 1;

   typedef struct {
      bit          wb;
      logic [13:0] addr;
      logic [63:0] data;
   } mem_exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] cpu_addr;
   logic        cpu_rd;
   logic        cpu_wr;
   logic [15:0] cpu_wdata;
   logic [15:0] cpu_rdata;
   logic        cpu_stall;
   logic [13:0] mem_addr;
   logic        mem_rd;
   logic        mem_wr;
   logic [63:0] mem_wdata;
   logic [63:0] mem_rdata;
   logic        mem_rdy;
   logic [MCW-1:0] miss_cnt;

   int total = 0;
   int bad = 0;
   int rdy_delay = -1;
   int stray_req = 0;
   int stray_done = 0;
   int exp_miss = 0;

   logic [63:0] mem_line [16384];
   logic [15:0] ref_word [65536];
   bit          m_valid [64];
   bit          m_dirty [64];
   logic [7:0]  m_tag [64];

   logic [15:0] exp_rd [$];
   mem_exp_t    exp_mem [$];

   dcache_ctrl #(.INDEX_W(6), .MISS_CNT_W(MCW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cpu_addr  (cpu_addr),
      .cpu_rd    (cpu_rd),
      .cpu_wr    (cpu_wr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_stall (cpu_stall),
      .mem_addr  (mem_addr),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_rdy   (mem_rdy),
      .miss_cnt  (miss_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [63:0] act,
                        input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] line_of(input logic [13:0] l);
      logic [63:0] v;
      for (int w = 0; w < 4; w++) v[w*16 +: 16] = ref_word[{l, w[1:0]}];
      return v;
   endfunction

   task automatic set_line(input logic [13:0] l, input logic [63:0] v);
      mem_line[l] = v;
      for (int w = 0; w < 4; w++) ref_word[{l, w[1:0]}] = v[w*16 +: 16];
   endtask

   task automatic resync();
      for (int l = 0; l < 16384; l++) set_line(l[13:0], mem_line[l]);
      for (int i = 0; i < 64; i++) begin
         m_valid[i] = 0;
         m_dirty[i] = 0;
      end
      exp_miss = 0;
   endtask

   task automatic check_cnt();
      check("miss_cnt", 64'(miss_cnt),
            64'((exp_miss > CNT_MAX) ? CNT_MAX : exp_miss));
   endtask

   // Issue one request, predict traffic and data, hold until not stalled
   task automatic do_req(input bit wr, input logic [15:0] a,
                         input logic [15:0] d, input bit drop);
      logic [7:0] tg;
      int idx;
      bit hit;
      int n;
      tg  = a[15:8];
      idx = int'(a[7:2]);
      hit = m_valid[idx] && (m_tag[idx] == tg);
      if (!hit) begin
         mem_exp_t e;
         exp_miss++;
         if (m_valid[idx] && m_dirty[idx]) begin
            e.wb   = 1;
            e.addr = {m_tag[idx], a[7:2]};
            e.data = line_of(e.addr);
            exp_mem.push_back(e);
         end
         e.wb   = 0;
         e.addr = {tg, a[7:2]};
         e.data = '0;
         exp_mem.push_back(e);
         m_valid[idx] = 1;
         m_tag[idx]   = tg;
         m_dirty[idx] = 0;
      end
      if (!(drop && !hit)) begin
         if (wr) begin
            ref_word[a] = d;
            m_dirty[idx] = 1;
         end else begin
            exp_rd.push_back(ref_word[a]);
         end
      end
      cpu_addr  = a;
      cpu_wdata = d;
      cpu_rd    = !wr;
      cpu_wr    = wr;
      @(negedge clk);
      check("stall_on_issue", 64'(cpu_stall), 64'(!hit));
      n = 0;
      if (drop && !hit) begin
         @(posedge clk);
         #1;
         cpu_rd = 0;
         cpu_wr = 0;
         while (exp_mem.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
         end
      end else begin
         while (cpu_stall && n < 300) begin
            @(negedge clk);
            n++;
         end
      end
      if (n >= 300) begin
         total++;
         bad++;
         $display("FAIL req_timeout: got stalled want done addr %h", a);
      end
      @(posedge clk);
      #1;
      cpu_rd = 0;
      cpu_wr = 0;
      check_cnt();
   endtask

   // Main memory responder
   initial begin
      int wait_left;
      wait_left = -1;
      mem_rdy   = 0;
      mem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            mem_rdy   = 0;
            wait_left = -1;
         end else if (mem_rdy) begin
            mem_rdy   = 0;
            wait_left = -1;
         end else if (mem_rd || mem_wr) begin
            if (wait_left < 0)
               wait_left = (rdy_delay < 0) ? int'($urandom_range(0, 3))
                                           : rdy_delay;
            if (wait_left == 0) begin
               if (mem_wr) mem_line[mem_addr] = mem_wdata;
               else mem_rdata = mem_line[mem_addr];
               mem_rdy = 1;
            end else begin
               wait_left--;
            end
         end else if (stray_req != stray_done) begin
            stray_done = stray_req;
            mem_rdata  = {$urandom, $urandom};
            mem_rdy    = 1;
         end
      end
   end

   // Load data monitor
   always @(negedge clk) begin
      if (rst_n && cpu_rd && !cpu_stall) begin
         if (exp_rd.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rdata_unexpected: got %h want none", cpu_rdata);
         end else begin
            check("rdata", 64'(cpu_rdata), 64'(exp_rd.pop_front()));
         end
      end
   end

   // Line interface monitor: stability, exclusivity, traffic order
   bit          trk = 0;
   logic [81:0] snap;
   always @(negedge clk) begin
      if (!rst_n) begin
         trk = 0;
      end else if (mem_rd || mem_wr) begin
         check("rd_wr_exclusive", 64'(mem_rd && mem_wr), 64'(0));
         check("stall_in_miss", 64'(cpu_stall), 64'(1));
         if (trk)
            check("hs_stable_ctl", 64'({mem_rd, mem_wr, mem_addr}),
                  64'(snap[81:64]));
         if (trk && mem_wr)
            check("hs_stable_data", mem_wdata, snap[63:0]);
         snap = {2'b00, mem_rd, mem_wr, mem_addr, mem_wdata};
         trk  = 1;
         if (mem_rdy) begin
            trk = 0;
            if (exp_mem.size() == 0) begin
               total++;
               bad++;
               $display("FAIL mem_unexpected: got wr=%0d addr %h want none",
                        mem_wr, mem_addr);
            end else begin
               mem_exp_t e;
               e = exp_mem.pop_front();
               check("mem_kind_wb", 64'(mem_wr), 64'(e.wb));
               check("mem_addr", 64'(mem_addr), 64'(e.addr));
               if (e.wb) check("wb_data", mem_wdata, e.data);
            end
         end
      end else begin
         trk = 0;
      end
   end

   always @(negedge clk) begin
      if (rst_n)
         assert (!(cpu_rd && cpu_wr))
         else $error("FAIL illegal rd+wr request");
   end

   initial begin
      logic [7:0] tags [4];
      logic [5:0] idxs [4];
      int n;
      int cnt_before;
      tags[0] = 8'h00; tags[1] = 8'h01; tags[2] = 8'h40; tags[3] = 8'hFF;
      idxs[0] = 6'd0;  idxs[1] = 6'd1;  idxs[2] = 6'd2;  idxs[3] = 6'd63;
      rst_n = 0;
      cpu_addr = '0;
      cpu_rd = 0;
      cpu_wr = 0;
      cpu_wdata = '0;
      for (int l = 0; l < 16384; l++) set_line(l[13:0], {$urandom, $urandom});
      set_line(14'h0041, 64'hDDDD_CCCC_BBBB_AAAA);
      repeat (3) @(posedge clk);
      #1;
      check("rst_stall", 64'(cpu_stall), 0);
      check("rst_mem_rd", 64'(mem_rd), 0);
      check("rst_mem_wr", 64'(mem_wr), 0);
      check("rst_mem_addr", 64'(mem_addr), 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_rdata", 64'(cpu_rdata), 0);
      check("rst_miss_cnt", 64'(miss_cnt), 0);
      rst_n = 1;
      @(posedge clk);
      #1;

      // Cold read, hit, write hit, dirty eviction
      rdy_delay = 3;
      do_req(0, 16'h0104, 16'h0, 0);
      do_req(0, 16'h0106, 16'h0, 0);
      do_req(1, 16'h0105, 16'h1234, 0);
      rdy_delay = -1;
      do_req(0, 16'h0504, 16'h0, 0);
      // Clean eviction
      do_req(0, 16'h0900, 16'h0, 0);
      do_req(0, 16'h0D00, 16'h0, 0);
      // Long handshake hold, then stray rdy while idle
      rdy_delay = 20;
      do_req(0, 16'h2230, 16'h0, 0);
      rdy_delay = -1;
      cnt_before = int'(miss_cnt);
      stray_req++;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      check("stray_cnt", 64'(miss_cnt), 64'(cnt_before));
      check("stray_mem_rd", 64'(mem_rd), 0);
      check("stray_mem_wr", 64'(mem_wr), 0);
      do_req(0, 16'h2231, 16'h0, 0);
      // Dropped miss still installs the line
      do_req(0, 16'h3310, 16'h0, 1);
      do_req(0, 16'h3310, 16'h0, 0);
      // Address wrap line 0x3FFF
      do_req(1, 16'hFFFF, 16'hBEEF, 0);
      do_req(0, 16'hFFFF, 16'h0, 0);

      // Random traffic
      for (int i = 0; i < 300; i++) begin
         logic [15:0] a;
         a = {tags[$urandom_range(0, 3)], idxs[$urandom_range(0, 3)],
              2'($urandom_range(0, 3))};
         do_req($urandom_range(0, 9) < 4, a, 16'($urandom),
                $urandom_range(0, 19) == 0);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end
      check("miss_cnt_saturated", 64'(miss_cnt), 64'(CNT_MAX));

      // Reset in the middle of a writeback
      do_req(0, 16'h0104, 16'h0, 0);
      do_req(1, 16'h0105, 16'h7777, 0);
      rdy_delay = 1000;
      cpu_addr = 16'h0504;
      cpu_rd = 1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!mem_wr && n < 20);
      check("rst_wb_started", 64'(mem_wr), 1);
      #2 rst_n = 0;
      #1;
      check("rst_async_mem_wr", 64'(mem_wr), 0);
      check("rst_async_mem_rd", 64'(mem_rd), 0);
      check("rst_async_stall", 64'(cpu_stall), 0);
      cpu_rd = 0;
      exp_mem.delete();
      repeat (2) @(posedge clk);
      #3 rst_n = 1;
      rdy_delay = -1;
      resync();
      check("post_rst_cnt", 64'(miss_cnt), 0);
      @(posedge clk);
      #1;
      do_req(0, 16'h0105, 16'h0, 0);

      repeat (3) begin
         @(posedge clk);
         #1;
      end
      check("rd_queue_empty", 64'(exp_rd.size()), 0);
      check("mem_queue_empty", 64'(exp_mem.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
